// File: rtl/ctrl_pipeline.sv
// Control-path pipeline (ID/EX, EX/MEM, MEM/WB) with hazard detection, branch flush and forwarding.
// Define CTRL_PIPE_FWD_EN to enable operand forwarding; otherwise RAW hazards stall until the producer clears EX/MEM.
module ctrl_pipeline #(
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [4:0]         id_ex,
    input  logic [2:0]         id_m,
    input  logic [2:0]         id_wb,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               ex_zero,
    input  logic               mem_ack,
    output logic               ex_alu_src_b,
    output logic [3:0]         ex_alu_op,
    output logic               mem_req,
    output logic               mem_we,
    output logic               wb_reg_write,
    output logic [1:0]         wb_mem_to_reg,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               stall,
    output logic               flush,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    logic               idex_valid_q, idex_valid_d;
    logic [4:0]         idex_ex_q, idex_ex_d;
    logic [2:0]         idex_m_q, idex_m_d;
    logic [2:0]         idex_wb_q, idex_wb_d;
    logic [RADDR_W-1:0] idex_rd_q, idex_rd_d;
    logic               exmem_valid_q, exmem_valid_d;
    logic               exmem_we_q, exmem_we_d;
    logic [2:0]         exmem_wb_q, exmem_wb_d;
    logic [RADDR_W-1:0] exmem_rd_q, exmem_rd_d;
    logic               memwb_valid_q, memwb_valid_d;
    logic [2:0]         memwb_wb_q, memwb_wb_d;
    logic [RADDR_W-1:0] memwb_rd_q, memwb_rd_d;

    logic taken, hazard, mem_load, mem_busy;

    assign taken    = idex_valid_q & idex_m_q[2] & (idex_m_q[1] ? ex_zero : ~ex_zero);
    assign mem_load = (exmem_wb_q[1:0] == 2'b11);
    assign mem_req  = exmem_valid_q & (exmem_we_q | mem_load);
    assign mem_busy = mem_req & ~mem_ack;

`ifdef CTRL_PIPE_FWD_EN
    logic [RADDR_W-1:0] idex_rs1_q, idex_rs1_d;
    logic [RADDR_W-1:0] idex_rs2_q, idex_rs2_d;
    logic               ex_load, exmem_fwd_ok, memwb_fwd_ok;
    logic [RADDR_W-1:0] ex_rs [2];
    logic [1:0]         fwd_sel [2];

    assign ex_load = (idex_wb_q[1:0] == 2'b11);
    assign hazard  = idex_valid_q & ex_load & (idex_rd_q != '0)
                   & ((idex_rd_q == id_rs1) | (idex_rd_q == id_rs2)) & id_valid;

    // A load sitting in EX/MEM has no data yet; load_use already spaced it out to MEM/WB.
    assign exmem_fwd_ok = exmem_valid_q & exmem_wb_q[2] & ~mem_load & (exmem_rd_q != '0);
    assign memwb_fwd_ok = memwb_valid_q & memwb_wb_q[2] & (memwb_rd_q != '0);
    assign ex_rs[0] = idex_rs1_q;
    assign ex_rs[1] = idex_rs2_q;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] = (exmem_fwd_ok && exmem_rd_q == ex_rs[gi]) ? 2'b01 :
                             (memwb_fwd_ok && memwb_rd_q == ex_rs[gi]) ? 2'b10 : 2'b00;
    end
    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    always_comb begin
        idex_rs1_d = idex_rs1_q;
        idex_rs2_d = idex_rs2_q;
        if (!mem_busy) begin
            idex_rs1_d = (taken || hazard || !id_valid) ? '0 : id_rs1;
            idex_rs2_d = (taken || hazard || !id_valid) ? '0 : id_rs2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_rs1_q <= '0;
            idex_rs2_q <= '0;
        end else begin
            idex_rs1_q <= idex_rs1_d;
            idex_rs2_q <= idex_rs2_d;
        end
    end
`else
    logic raw_idex, raw_exmem;

    // Without forwarding the consumer waits in ID until the producer has reached MEM/WB.
    assign raw_idex  = idex_valid_q & idex_wb_q[2] & (idex_rd_q != '0)
                     & ((idex_rd_q == id_rs1) | (idex_rd_q == id_rs2));
    assign raw_exmem = exmem_valid_q & exmem_wb_q[2] & (exmem_rd_q != '0)
                     & ((exmem_rd_q == id_rs1) | (exmem_rd_q == id_rs2));
    assign hazard    = id_valid & (raw_idex | raw_exmem);
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
`endif

    always_comb begin
        idex_valid_d  = idex_valid_q;
        idex_ex_d     = idex_ex_q;
        idex_m_d      = idex_m_q;
        idex_wb_d     = idex_wb_q;
        idex_rd_d     = idex_rd_q;
        exmem_valid_d = exmem_valid_q;
        exmem_we_d    = exmem_we_q;
        exmem_wb_d    = exmem_wb_q;
        exmem_rd_d    = exmem_rd_q;
        memwb_valid_d = memwb_valid_q;
        memwb_wb_d    = memwb_wb_q;
        memwb_rd_d    = memwb_rd_q;
        stall         = 1'b0;
        flush         = 1'b0;
        if (mem_busy) begin
            stall = 1'b1;
        end else begin
            exmem_valid_d = idex_valid_q;
            exmem_we_d    = idex_m_q[0];
            exmem_wb_d    = idex_wb_q;
            exmem_rd_d    = idex_rd_q;
            memwb_valid_d = exmem_valid_q;
            memwb_wb_d    = exmem_wb_q;
            memwb_rd_d    = exmem_rd_q;
            flush         = taken;
            stall         = ~taken & hazard;
            if (taken || hazard || !id_valid) begin
                idex_valid_d = 1'b0;
                idex_ex_d    = '0;
                idex_m_d     = '0;
                idex_wb_d    = '0;
                idex_rd_d    = '0;
            end else begin
                idex_valid_d = 1'b1;
                idex_ex_d    = id_ex;
                idex_m_d     = id_m;
                idex_wb_d    = id_wb;
                idex_rd_d    = id_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_valid_q  <= 1'b0;
            idex_ex_q     <= '0;
            idex_m_q      <= '0;
            idex_wb_q     <= '0;
            idex_rd_q     <= '0;
            exmem_valid_q <= 1'b0;
            exmem_we_q    <= 1'b0;
            exmem_wb_q    <= '0;
            exmem_rd_q    <= '0;
            memwb_valid_q <= 1'b0;
            memwb_wb_q    <= '0;
            memwb_rd_q    <= '0;
        end else begin
            idex_valid_q  <= idex_valid_d;
            idex_ex_q     <= idex_ex_d;
            idex_m_q      <= idex_m_d;
            idex_wb_q     <= idex_wb_d;
            idex_rd_q     <= idex_rd_d;
            exmem_valid_q <= exmem_valid_d;
            exmem_we_q    <= exmem_we_d;
            exmem_wb_q    <= exmem_wb_d;
            exmem_rd_q    <= exmem_rd_d;
            memwb_valid_q <= memwb_valid_d;
            memwb_wb_q    <= memwb_wb_d;
            memwb_rd_q    <= memwb_rd_d;
        end
    end

    assign ex_alu_src_b  = idex_valid_q & idex_ex_q[4];
    assign ex_alu_op     = idex_valid_q ? idex_ex_q[3:0] : 4'b0000;
    assign mem_we        = exmem_valid_q & exmem_we_q;
    assign wb_reg_write  = memwb_valid_q & memwb_wb_q[2];
    assign wb_mem_to_reg = memwb_valid_q ? memwb_wb_q[1:0] : 2'b00;
    assign wb_rd         = memwb_valid_q ? memwb_rd_q : '0;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed-vector bench for ctrl_pipeline; expectations follow whichever CTRL_PIPE_FWD_EN build is compiled.
module tb_ctrl_pipeline;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_ex;
    logic [2:0] id_m;
    logic [2:0] id_wb;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       ex_zero, mem_ack;
    logic       ex_alu_src_b;
    logic [3:0] ex_alu_op;
    logic       mem_req, mem_we, wb_reg_write;
    logic [1:0] wb_mem_to_reg;
    logic [4:0] wb_rd;
    logic       stall, flush;
    logic [1:0] fwd_a, fwd_b;

    int checks_total  = 0;
    int checks_passed = 0;

    localparam logic [4:0] EX_IMM = 5'b10000;
    localparam logic [4:0] EX_REG = 5'b00000;
    localparam logic [4:0] EX_SUB = 5'b00001;
    localparam logic [2:0] M_NONE = 3'b000;
    localparam logic [2:0] M_SW   = 3'b001;
    localparam logic [2:0] M_BEQ  = 3'b110;
    localparam logic [2:0] M_BNE  = 3'b100;
    localparam logic [2:0] WB_ALU = 3'b100;
    localparam logic [2:0] WB_LD  = 3'b111;
    localparam logic [2:0] WB_NO  = 3'b000;

    ctrl_pipeline #(.RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_zero(ex_zero), .mem_ack(mem_ack),
        .ex_alu_src_b(ex_alu_src_b), .ex_alu_op(ex_alu_op), .mem_req(mem_req), .mem_we(mem_we),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
            $display("check %s ok: %0h", tag, obs);
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {11'd0, ex_alu_src_b, ex_alu_op, mem_req, mem_we, wb_reg_write, wb_mem_to_reg,
                wb_rd, stall, flush, fwd_a, fwd_b};
    endfunction

    function automatic logic [31:0] wb_bus();
        return {24'd0, wb_reg_write, wb_mem_to_reg, wb_rd};
    endfunction

    task automatic drive_id(input logic v, input logic [4:0] ex, input logic [2:0] m,
                            input logic [2:0] wb, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid = v; id_ex = ex; id_m = m; id_wb = wb;
        id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    task automatic nop();
        drive_id(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drain();
        nop();
        repeat (4) cyc();
    endtask

    initial begin
        rst = 1'b1; ex_zero = 1'b0; mem_ack = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        settle();
        check_eq("reset_outputs", all_out(), 32'd0);
        rst = 1'b0;
        cyc();

        // Plain ALU op: ID to WB in three cycles
        drive_id(1'b1, EX_IMM, M_NONE, WB_ALU, 5'd3, 5'd0, 5'd0);
        settle(); check_eq("lat_stall", stall, 0); cyc();
        nop();
        settle(); check_eq("lat_ex_src", ex_alu_src_b, 1); check_eq("lat_wb_early", wb_reg_write, 0); cyc();
        settle(); check_eq("lat_memreq", mem_req, 0); cyc();
        settle(); check_eq("lat_wb", wb_bus(), {24'd0, 1'b1, 2'b00, 5'd3}); cyc();
        settle(); check_eq("lat_wb_drop", wb_reg_write, 0);
        drain();

        // addi x1 then add x2 using x1
        drive_id(1'b1, EX_IMM, M_NONE, WB_ALU, 5'd1, 5'd0, 5'd0);
        settle(); cyc();
`ifdef CTRL_PIPE_FWD_EN
        drive_id(1'b1, EX_REG, M_NONE, WB_ALU, 5'd2, 5'd1, 5'd1);
        settle(); check_eq("raw_nostall", stall, 0); cyc();
        nop();
        settle(); check_eq("raw_fwd", {fwd_a, fwd_b}, 4'b0101); cyc();
        settle(); cyc();
        settle(); check_eq("raw_wb", wb_bus(), {24'd0, 1'b1, 2'b00, 5'd2});
`else
        drive_id(1'b1, EX_REG, M_NONE, WB_ALU, 5'd2, 5'd1, 5'd0);
        settle(); check_eq("raw_stall1", {stall, fwd_a, fwd_b}, 5'b10000); cyc();
        settle(); check_eq("raw_stall2", {stall, fwd_a, fwd_b}, 5'b10000); cyc();
        settle(); check_eq("raw_release", stall, 0);
        check_eq("raw_wb_addi", wb_bus(), {24'd0, 1'b1, 2'b00, 5'd1}); cyc();
        nop();
        settle(); check_eq("raw_fwd_off", {fwd_a, fwd_b}, 4'b0000); cyc();
        settle(); cyc();
        settle(); check_eq("raw_wb", wb_bus(), {24'd0, 1'b1, 2'b00, 5'd2});
`endif
        drain();

        // lw x5 then add x6,x5,x0
        drive_id(1'b1, EX_IMM, M_NONE, WB_LD, 5'd5, 5'd0, 5'd0);
        settle(); cyc();
        drive_id(1'b1, EX_REG, M_NONE, WB_ALU, 5'd6, 5'd5, 5'd0);
        settle(); check_eq("lu_stall", stall, 1); cyc();
        settle(); check_eq("lu_memreq", {mem_req, mem_we}, 2'b10);
`ifdef CTRL_PIPE_FWD_EN
        check_eq("lu_stall_once", stall, 0); cyc();
        nop();
        settle(); check_eq("lu_fwd", {fwd_a, fwd_b}, 4'b1000);
        check_eq("lu_wb", wb_bus(), {24'd0, 1'b1, 2'b11, 5'd5});
`else
        check_eq("lu_stall2", stall, 1); cyc();
        settle(); check_eq("lu_release", stall, 0);
        check_eq("lu_wb", wb_bus(), {24'd0, 1'b1, 2'b11, 5'd5}); cyc();
        nop();
        settle(); check_eq("lu_fwd_off", {fwd_a, fwd_b}, 4'b0000);
`endif
        drain();

        // beq taken squashes the wrong-path addi
        drive_id(1'b1, EX_SUB, M_BEQ, WB_NO, 5'd0, 5'd0, 5'd0);
        settle(); cyc();
        drive_id(1'b1, EX_IMM, M_NONE, WB_ALU, 5'd7, 5'd0, 5'd0); ex_zero = 1'b1;
        settle(); check_eq("beq_flush", {flush, stall}, 2'b10); cyc();
        nop(); ex_zero = 1'b0;
        settle(); check_eq("beq_bubble", {flush, ex_alu_src_b}, 2'b00); cyc();
        settle(); cyc();
        settle(); check_eq("beq_squashed_wb", wb_reg_write, 0);
        drain();

        // bne with zero set is not taken
        drive_id(1'b1, EX_SUB, M_BNE, WB_NO, 5'd0, 5'd0, 5'd0);
        settle(); cyc();
        drive_id(1'b1, EX_IMM, M_NONE, WB_ALU, 5'd7, 5'd0, 5'd0); ex_zero = 1'b1;
        settle(); check_eq("bne_noflush", flush, 0); cyc();
        nop(); ex_zero = 1'b0;
        settle(); check_eq("bne_ex", ex_alu_src_b, 1); cyc();
        settle(); cyc();
        settle(); check_eq("bne_wb", wb_bus(), {24'd0, 1'b1, 2'b00, 5'd7});
        drain();

        // sw held in MEM for three cycles without ack
        drive_id(1'b1, EX_IMM, M_SW, WB_NO, 5'd0, 5'd0, 5'd0);
        settle(); cyc();
        drive_id(1'b1, EX_IMM, M_NONE, WB_ALU, 5'd8, 5'd0, 5'd0);
        settle(); cyc();
        drive_id(1'b1, EX_IMM, M_NONE, WB_ALU, 5'd9, 5'd0, 5'd0); mem_ack = 1'b0;
        settle(); check_eq("sw_busy0", {mem_req, mem_we, stall, flush}, 4'b1110);
        check_eq("sw_ex_held0", ex_alu_src_b, 1); cyc();
        settle(); check_eq("sw_busy1", {mem_req, mem_we, stall}, 3'b111); cyc();
        settle(); check_eq("sw_busy2", {mem_req, mem_we, stall}, 3'b111);
        check_eq("sw_frozen_wb", wb_reg_write, 0); cyc();
        mem_ack = 1'b1;
        settle(); check_eq("sw_ack", {mem_req, stall}, 2'b10); cyc();
        nop();
        settle(); check_eq("sw_after", {mem_req, ex_alu_src_b}, 2'b01); cyc();
        settle(); check_eq("sw_wb_x8", wb_bus(), {24'd0, 1'b1, 2'b00, 5'd8});
        drain();

        // Asynchronous reset while a load is stuck in MEM
        drive_id(1'b1, EX_IMM, M_NONE, WB_LD, 5'd10, 5'd0, 5'd0);
        settle(); cyc();
        nop();
        settle(); cyc();
        mem_ack = 1'b0;
        settle(); check_eq("rst_pre_memreq", mem_req, 1);
        #1 rst = 1'b1;
        #1 check_eq("rst_async", all_out(), 32'd0);
        cyc();
        settle(); check_eq("rst_hold", all_out(), 32'd0);
        rst = 1'b0; mem_ack = 1'b1;
        drive_id(1'b1, EX_IMM, M_NONE, WB_ALU, 5'd11, 5'd0, 5'd0);
        cyc();
        nop();
        settle(); check_eq("post_rst_wb1", wb_reg_write, 0); cyc();
        settle(); check_eq("post_rst_wb2", wb_reg_write, 0); cyc();
        settle(); check_eq("post_rst_wb3", wb_bus(), {24'd0, 1'b1, 2'b00, 5'd11});
        drain();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
